// File: rtl/boa_pmu_seq_if.sv
// ---------------------------------------------------------------------------
// pmu_bus
// Request lines carried from the CPU-side PMU peripheral to the power/reset
// sequencer. Both lines are levels, one bit each.
//   rst  : CPU asks for a system reset
//   shdn : CPU asks for a drain-then-power-off shutdown
// Modports:
//   PMU : sequencer side, reads the requests
//   CPU : peripheral side, drives the requests
// ---------------------------------------------------------------------------
interface pmu_bus;
  logic rst;
  logic shdn;

  modport PMU (input rst, input shdn);
  modport CPU (output rst, output shdn);
endinterface

// File: rtl/boa_pmu_seq.sv
// ---------------------------------------------------------------------------
// boa_pmu_seq
// Power/reset sequencer on the PMU side of the power management bus.
// It stretches every reset cause to a fixed RST_CYCLES-wide sys_rst pulse
// and runs a drain-then-power-off shutdown. A shutdown waits for the CPU and
// bus to go idle, or gives up after DRAIN_TIMEOUT cycles. Once off, the
// sequencer stays off until an external wake.
//
// Parameters:
//   RST_CYCLES    : cycles sys_rst is held after any reset cause (>= 1)
//   DRAIN_TIMEOUT : maximum cycles spent waiting for idle (>= 1)
//
// Ports:
//   clk      : clock
//   rst      : synchronous reset, active-high, overrides every state
//   pmb      : pmu_bus.PMU, rst/shdn request levels from the CPU
//   idle     : CPU/bus quiescent, no outstanding transactions
//   wake     : external wake request (level), honoured only when off
//   sys_rst  : system reset to core and peripherals, active-high
//   cpu_halt : stall the CPU pipeline
//   pwr_off  : power-off request to the board regulator
//   drain_to : sticky, last shutdown ended by timeout rather than by idle
//   busy     : sequencer is anywhere other than RUN
//
// All outputs come straight from flops, so there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module boa_pmu_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  pmu_bus.PMU  pmb,
  input  logic idle,
  input  logic wake,
  output logic sys_rst,
  output logic cpu_halt,
  output logic pwr_off,
  output logic drain_to,
  output logic busy
);

  // The counter is shared by the reset stretch and the drain timeout, so it
  // is sized for whichever of the two loads is larger.
  localparam int MAX_CNT = (RST_CYCLES > DRAIN_TIMEOUT) ? RST_CYCLES : DRAIN_TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] RST_LOAD   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ZERO   = '0;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_RUN      = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_OFF      = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          drain_to_nxt;

  // Next-state logic. Each state reacts only to the inputs it cares about:
  // requests are ignored while reset is being stretched, once a shutdown is
  // committed, and while the core is powered off. In RUN a reset request
  // beats a shutdown request raised in the same cycle. In DRAIN, idle is
  // checked before the timeout, so a bus that goes quiet on the last count
  // still gives a clean (non-timeout) shutdown.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    drain_to_nxt = drain_to;

    case (state)
      ST_RST_HOLD: begin
        if (cnt == CNT_ZERO) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      ST_RUN: begin
        if (pmb.rst) begin
          state_nxt = ST_RST_HOLD;
          cnt_nxt   = RST_LOAD;
        end else if (pmb.shdn) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = DRAIN_LOAD;
        end
      end

      ST_DRAIN: begin
        if (idle) begin
          state_nxt = ST_OFF;
        end else if (cnt == CNT_ZERO) begin
          state_nxt    = ST_OFF;
          drain_to_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      ST_OFF: begin
        if (wake) begin
          state_nxt = ST_RST_HOLD;
          cnt_nxt   = RST_LOAD;
        end
      end

      default: begin
        state_nxt = ST_RST_HOLD;
        cnt_nxt   = RST_LOAD;
      end
    endcase
  end

  // State, counter and output registers. The outputs are decoded from the
  // state being entered, so each output flop always equals the Moore decode
  // of the state register while staying a clean flop output. drain_to is
  // cleared only here by rst; wake and later clean shutdowns leave it alone
  // so software can read it after restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RST_HOLD;
      cnt      <= RST_LOAD;
      drain_to <= 1'b0;
      sys_rst  <= 1'b1;
      cpu_halt <= 1'b0;
      pwr_off  <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      drain_to <= drain_to_nxt;
      sys_rst  <= (state_nxt == ST_RST_HOLD) || (state_nxt == ST_OFF);
      cpu_halt <= (state_nxt == ST_DRAIN) || (state_nxt == ST_OFF);
      pwr_off  <= (state_nxt == ST_OFF);
      busy     <= (state_nxt != ST_RUN);
    end
  end

endmodule
